key_sched_ctrl: RTL

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/round_key_store.sv | 33 +++
 rtl/key_sched_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: sizes, controller state type, rcon generation.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned RCON_W     = 8;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Write-port payload into the round-key store.
  typedef struct packed {
    logic             en;
    logic [IDX_W-1:0] idx;
    logic [KEY_W-1:0] data;
  } rk_wr_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // rcon for round 1..NUM_ROUNDS (x^(round-1)); zero outside that range.
  function automatic logic [RCON_W-1:0] rcon(input logic [IDX_W-1:0] round);
    logic [RCON_W-1:0] c;
    c = 8'h01;
    for (int unsigned i = 2; i <= NUM_ROUNDS; i++) begin
      if (IDX_W'(i) <= round) c = xtime(c);
    end
    if ((round == '0) || (round > IDX_W'(NUM_ROUNDS))) c = '0;
    return c;
  endfunction

endpackage

// File: rtl/round_key_store.sv
// Eleven 128-bit round-key registers with one write port and one combinational read port.
module round_key_store
  import aes_pkg::*;
(
  input  logic             clk,
  input  rk_wr_t           wr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_data_c
);

  logic [KEY_W-1:0] mem_q [NUM_KEYS];
  logic [KEY_W-1:0] mem_d [NUM_KEYS];

  // Next contents: only the addressed entry takes the write data.
  always_comb begin
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      mem_d[i] = mem_q[i];
      if (wr.en && (wr.idx == IDX_W'(i))) mem_d[i] = wr.data;
    end
  end

  // Key storage is deliberately left out of reset; contents are only meaningful once key_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read port returns zero for indices beyond the last round key.
  always_comb begin
    rd_data_c = '0;
    if (rd_idx < IDX_W'(NUM_KEYS)) rd_data_c = mem_q[rd_idx];
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequencer for an external key_evolution datapath; collects the 11 AES-128 round keys.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] evolutioned_key_in,
  input  logic [IDX_W-1:0] rk_idx,
  output logic             load_key,
  output logic             clk_en,
  output logic [KEY_W-1:0] round_constant,
  output logic             busy,
  output logic             done,
  output logic             key_valid,
  output logic [KEY_W-1:0] rk_out
);

  localparam int unsigned      CNT_W    = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUND_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    round_q, round_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cap_q, cap_d;
  logic                load_key_q, load_key_d;
  logic                clk_en_q, clk_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                key_valid_q, key_valid_d;
  logic [RCON_W-1:0]   rcon_q, rcon_d;
  rk_wr_t              wr_c;

  // Next-state, store write and registered-output decode.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    wr_c        = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          round_d     = IDX_W'(1);
          cnt_d       = '0;
          key_valid_d = 1'b0;
          wr_c.en     = 1'b1;
          wr_c.idx    = '0;
          wr_c.data   = key;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        // Datapath result is valid the cycle after clk_en.
        if (cap_q) begin
          wr_c.en   = 1'b1;
          wr_c.idx  = round_q;
          wr_c.data = evolutioned_key_in;
          round_d   = round_q + IDX_W'(1);
          if (round_q == IDX_W'(NUM_ROUNDS)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort cancels everything in flight, including a same-cycle capture.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      round_d     = '0;
      cnt_d       = '0;
      key_valid_d = 1'b0;
      wr_c        = '0;
    end

    if (state_d == ST_DONE) key_valid_d = 1'b1;

    load_key_d = (state_d == ST_LOAD);
    clk_en_d   = (state_d == ST_RUN) && (cnt_d == CNT_LAST);
    cap_d      = clk_en_q && (state_d == ST_RUN);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
    rcon_d     = (state_d == ST_RUN) ? rcon(round_d) : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      load_key_q  <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rcon_q      <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      load_key_q  <= load_key_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      rcon_q      <= rcon_d;
    end
  end

  round_key_store u_store (
    .clk       (clk),
    .wr        (wr_c),
    .rd_idx    (rk_idx),
    .rd_data_c (rk_out)
  );

  assign load_key       = load_key_q;
  assign clk_en         = clk_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign key_valid      = key_valid_q;
  assign round_constant = {rcon_q, {(KEY_W - RCON_W){1'b0}}};

endmodule
